// File: rtl/phase_accum_ctl.sv
// Phase accumulator for the modulator DDS path.
// Registered accumulator with a frequency-word handshake. A new word can be applied
// at once, or at the next accumulator wrap so that an FSK switch keeps phase
// continuity. A per-cycle phase offset supports PSK. The output is the truncated,
// registered phase that addresses the sine ROM.
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   en, clr      accumulate enable and synchronous phase clear (clr has priority)
//   fw_in        frequency word offered by the producer
//   fw_valid     fw_in is valid
//   fw_ready     high when no word is pending
//   upd_on_wrap  0: apply the word on the next edge, 1: apply it at the next wrap
//   ph_off       phase offset added ahead of truncation
//   phase_out    top OUT_W bits of (acc + ph_off), registered
//   wrap         one-cycle pulse aligned with the phase_out of a carrying step
// OUT_W must be in 1..ACC_W.
module phase_accum_ctl #(
    parameter int unsigned ACC_W = 10,
    parameter int unsigned OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] fw_in,
    input  logic             fw_valid,
    output logic             fw_ready,
    input  logic             upd_on_wrap,
    input  logic [ACC_W-1:0] ph_off,
    output logic [OUT_W-1:0] phase_out,
    output logic             wrap
);

    // A word is either absent (idle) or captured and waiting to be applied.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fw_cur_q, fw_cur_d;
    logic [ACC_W-1:0] pend_fw_q, pend_fw_d;
    logic             carry_q, carry_d;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] off_sum;

    // Accumulation with its carry-out, and the offset phase ahead of truncation.
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, fw_cur_q};
        off_sum = acc_q + ph_off;
    end

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            fw_cur_q  <= '0;
            pend_fw_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fw_cur_q  <= fw_cur_d;
            pend_fw_q <= pend_fw_d;
            carry_q   <= carry_d;
        end
    end

    // Next-state logic: accumulator update, word capture and word apply.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fw_cur_d  = fw_cur_q;
        pend_fw_d = pend_fw_q;
        carry_d   = 1'b0;

        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d   = acc_sum[ACC_W-1:0];
            carry_d = acc_sum[ACC_W];
        end

        case (state_q)
            S_IDLE: begin
                if (fw_valid) begin
                    pend_fw_d = fw_in;
                    state_d   = S_PEND;
                end
            end
            S_PEND: begin
                // carry_d is only set by an enabled, uncleared step that used the old word.
                if (clr || !upd_on_wrap || carry_d) begin
                    fw_cur_d = pend_fw_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output stage: phase and wrap flag of the previous accumulation stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_out <= '0;
            wrap      <= 1'b0;
        end else begin
            phase_out <= off_sum[ACC_W-1 -: OUT_W];
            wrap      <= carry_q;
        end
    end

    assign fw_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_phase_accum_ctl.sv
// Directed bench for phase_accum_ctl: a 10/10 instance for the functional steps and
// a 16/8 instance for the wider-accumulator step.
module tb_phase_accum_ctl;

    logic clk = 1'b0;
    logic rst;

    // Instance A: ACC_W=10, OUT_W=10
    logic       en, clr, fw_valid, upd_on_wrap;
    logic [9:0] fw_in, ph_off;
    logic       fw_ready, wrap;
    logic [9:0] phase_out;

    // Instance B: ACC_W=16, OUT_W=8
    logic        b_en, b_clr, b_fw_valid, b_upd;
    logic [15:0] b_fw_in, b_ph_off;
    logic        b_fw_ready, b_wrap;
    logic [7:0]  b_phase;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    phase_accum_ctl #(.ACC_W(10), .OUT_W(10)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .fw_in(fw_in), .fw_valid(fw_valid),
        .fw_ready(fw_ready), .upd_on_wrap(upd_on_wrap), .ph_off(ph_off),
        .phase_out(phase_out), .wrap(wrap)
    );

    phase_accum_ctl #(.ACC_W(16), .OUT_W(8)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .clr(b_clr), .fw_in(b_fw_in), .fw_valid(b_fw_valid),
        .fw_ready(b_fw_ready), .upd_on_wrap(b_upd), .ph_off(b_ph_off),
        .phase_out(b_phase), .wrap(b_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; clr = 1'b0; fw_valid = 1'b0; upd_on_wrap = 1'b0;
        fw_in = '0; ph_off = '0;
        b_en = 1'b0; b_clr = 1'b0; b_fw_valid = 1'b0; b_upd = 1'b0;
        b_fw_in = '0; b_ph_off = '0;

        // Reset state
        tick(2);
        chk("rst_phase", 32'(phase_out), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_ready", 32'(fw_ready), 32'd1);
        rst = 1'b0;

        // Basic run: fw=100, immediate apply
        fw_in = 10'd100; fw_valid = 1'b1; en = 1'b1;
        tick(1);                                   // capture edge
        chk("basic_ready_low", 32'(fw_ready), 32'd0);
        fw_valid = 1'b0;
        tick(1);                                   // apply edge (still adds old word 0)
        chk("basic_ready_back", 32'(fw_ready), 32'd1);
        chk("basic_phase0", 32'(phase_out), 32'd0);
        tick(1);
        chk("basic_phase0b", 32'(phase_out), 32'd0);
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            chk("basic_phase", 32'(phase_out), 32'(100 * j));
            chk("basic_nowrap", 32'(wrap), 32'd0);
        end
        tick(1);
        chk("basic_phase76", 32'(phase_out), 32'd76);
        chk("basic_wrap", 32'(wrap), 32'd1);
        tick(1);
        chk("basic_phase176", 32'(phase_out), 32'd176);
        chk("basic_wrap_pulse", 32'(wrap), 32'd0);

        // Phase offset: fw=0, acc=0
        en = 1'b0; fw_in = 10'd0; fw_valid = 1'b1;
        tick(1);
        fw_valid = 1'b0;
        tick(1);                                   // fw_cur = 0
        clr = 1'b1;
        tick(1);                                   // acc = 0
        clr = 1'b0; ph_off = 10'd512;
        tick(1);
        chk("off_512", 32'(phase_out), 32'd512);
        ph_off = 10'd1023; en = 1'b1;
        tick(1);
        chk("off_1023", 32'(phase_out), 32'd1023);
        tick(1);
        chk("off_1023_hold", 32'(phase_out), 32'd1023);
        chk("off_fw0_nowrap", 32'(wrap), 32'd0);
        ph_off = 10'd0;
        tick(1);
        chk("off_acc_unchanged", 32'(phase_out), 32'd0);

        // Wrap-mode update: fw_cur=300, then offer 50 at acc=300
        en = 1'b0; fw_in = 10'd300; fw_valid = 1'b1;
        tick(1);
        fw_valid = 1'b0;
        tick(1);                                   // fw_cur = 300
        clr = 1'b1;
        tick(1);                                   // acc = 0
        clr = 1'b0; en = 1'b1; upd_on_wrap = 1'b1;
        tick(1);                                   // acc = 300
        fw_in = 10'd50; fw_valid = 1'b1;
        tick(1);                                   // capture, acc = 600
        fw_valid = 1'b0;
        chk("wm_ready0_a", 32'(fw_ready), 32'd0);
        chk("wm_phase300", 32'(phase_out), 32'd300);
        tick(1);                                   // acc = 900
        chk("wm_ready0_b", 32'(fw_ready), 32'd0);
        chk("wm_phase600", 32'(phase_out), 32'd600);
        tick(1);                                   // acc = 176, word applied
        chk("wm_ready1", 32'(fw_ready), 32'd1);
        chk("wm_phase900", 32'(phase_out), 32'd900);
        tick(1);
        chk("wm_phase176", 32'(phase_out), 32'd176);
        chk("wm_wrap", 32'(wrap), 32'd1);
        tick(1);
        chk("wm_phase226", 32'(phase_out), 32'd226);
        chk("wm_wrap_end", 32'(wrap), 32'd0);
        tick(1);
        chk("wm_phase276", 32'(phase_out), 32'd276);

        // Enable hold at acc=400 (fw_cur=50) with a word pending in wrap mode
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(8);                                   // acc = 400
        en = 1'b0; fw_in = 10'd77; fw_valid = 1'b1;
        tick(1);
        fw_valid = 1'b0;
        chk("hold_phase_first", 32'(phase_out), 32'd400);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("hold_phase", 32'(phase_out), 32'd400);
            chk("hold_nowrap", 32'(wrap), 32'd0);
            chk("hold_pending", 32'(fw_ready), 32'd0);
        end

        // Clear priority over enable, with the pending word
        en = 1'b1; clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_ready", 32'(fw_ready), 32'd1);
        tick(1);
        chk("clr_phase0", 32'(phase_out), 32'd0);
        chk("clr_nowrap", 32'(wrap), 32'd0);
        tick(1);
        chk("clr_word_applied", 32'(phase_out), 32'd77);
        chk("clr_nowrap2", 32'(wrap), 32'd0);

        // Reset mid-operation while a wrap pulse and a pending word are present
        tick(12);                                  // acc = 1078 mod 1024 = 54, carry
        fw_in = 10'd5; fw_valid = 1'b1;
        tick(1);
        fw_valid = 1'b0;
        chk("pre_rst_wrap", 32'(wrap), 32'd1);
        chk("pre_rst_phase", 32'(phase_out), 32'd54);
        chk("pre_rst_pending", 32'(fw_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_wrap", 32'(wrap), 32'd0);
        chk("mid_rst_phase", 32'(phase_out), 32'd0);
        chk("mid_rst_ready", 32'(fw_ready), 32'd1);
        #2;
        rst = 1'b0;
        tick(2);
        chk("post_rst_phase", 32'(phase_out), 32'd0);
        en = 1'b0;

        // Wider accumulator: ACC_W=16, OUT_W=8, fw=0x0100
        b_fw_in = 16'h0100; b_fw_valid = 1'b1; b_en = 1'b1;
        tick(1);
        b_fw_valid = 1'b0;
        tick(2);
        chk("b_phase0", 32'(b_phase), 32'd0);
        for (int j = 1; j <= 300; j++) begin
            tick(1);
            chk("b_phase", 32'(b_phase), 32'(j % 256));
            chk("b_wrap", 32'(b_wrap), 32'(j == 256));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_accum_ctl.md
Name: phase_accum_ctl

Overview:
- Parametrised phase accumulator for the modulator's DDS path; successor to the fixed 10-bit combinational adder.
- Adds a registered accumulator, a frequency-word handshake and phase-continuous word update on wrap (for FSK).
- Adds a phase offset (for PSK) and a truncated, registered phase output that drives the sine-ROM address.

Parameters:
ACC_W, 10, accumulator and frequency-word width in bits
OUT_W, 10, phase output width (top OUT_W bits of the accumulator); legal range 1 <= OUT_W <= ACC_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  accumulate enable
clr  input  1  synchronous phase clear
fw_in  input  ACC_W  new frequency word
fw_valid  input  1  fw_in valid
fw_ready  output  1  word can be accepted; equals !pending
upd_on_wrap  input  1  0 = apply word immediately, 1 = apply at next accumulator wrap
ph_off  input  ACC_W  phase offset, sampled every cycle
phase_out  output  OUT_W  registered phase = top OUT_W bits of (acc + ph_off)
wrap  output  1  one-cycle pulse, aligned with the phase_out value produced by a carrying accumulation

Behaviour:
- Internal state: acc[ACC_W], fw_cur[ACC_W], pend_fw[ACC_W], pending.
- Reset (async, rst=1) clears every register to 0: acc, fw_cur, pend_fw, pending, phase_out and wrap. fw_ready is therefore 1 during and after reset.
- Capture:
  - On an edge with fw_valid && fw_ready, pend_fw <= fw_in and pending <= 1.
  - No capture happens while pending=1; the producer holds fw_valid.
- Apply (fw_cur <= pend_fw, pending <= 0), evaluated from registered pending only:
  - upd_on_wrap=0: at the first edge after capture. Accumulation on that same edge still uses the old fw_cur; the new word is first used on the following edge.
  - upd_on_wrap=1: at the edge where en=1, clr=0 and acc + fw_cur carries out of ACC_W bits. That accumulation uses the old fw_cur, which gives a phase-continuous switch. If en stays 0, the word stays pending indefinitely.
  - clr=1 with pending=1 applies the word in either mode.
  - upd_on_wrap is sampled at every edge and may change while a word is pending.
- Accumulator, priority clr > en:
  - clr=1: acc <= 0, and the carry flag is 0.
  - en=1: acc <= (acc + fw_cur) mod 2^ACC_W, and the carry flag = carry-out of that addition.
  - Otherwise acc holds and the carry flag is 0.
- Output stage (one register), every edge:
  - phase_out <= ((acc + ph_off) mod 2^ACC_W)[ACC_W-1 : ACC_W-OUT_W].
  - wrap <= carry flag from the previous edge's accumulation.
  - Latency: an accumulation at edge N appears on phase_out and wrap after edge N+1.
- fw_cur=0 with en=1 holds acc constant and never wraps. fw_cur = 2^ACC_W-1 wraps on every edge except the first edge from acc=0.
- Asserting rst mid-operation discards any pending word and drops wrap immediately.
- No combinational path from inputs to outputs except fw_ready (from the pending register).

Test Plan:
- Reset then basic run:
  - Stimulus: rst pulse, then load fw=100 with upd_on_wrap=0, en=1, ph_off=0.
  - Required: fw_ready 1→0 for exactly one cycle. phase_out steps 0,100,200,...,1000,76. wrap=1 only in the cycle phase_out=76, and it is a single-cycle pulse.
- Phase offset:
  - Stimulus: fw=0, acc=0, ph_off=512.
  - Required: phase_out=512 one cycle after ph_off is applied. ph_off=1023 gives 1023; acc is unchanged.
- Wrap-mode update:
  - Stimulus: fw_cur=300, acc=0, upd_on_wrap=1; offer fw=50 while acc=300.
  - Required: fw_ready stays 0 until the edge where acc goes 900→176 (wrap). Subsequent acc is 226, 276, ...
- Clear priority:
  - Stimulus: en=1, clr=1 together with a pending word, upd_on_wrap=1.
  - Required: acc=0, word applied, no wrap pulse, fw_ready=1 next cycle.
- Enable hold:
  - Stimulus: en=0 for 5 cycles mid-run at acc=400.
  - Required: phase_out holds 400, no wrap. A pending word in wrap mode stays pending.
- Parameter sweep:
  - Stimulus: ACC_W=16, OUT_W=8, fw=0x0100.
  - Required: phase_out increments by 1 per cycle, wraps 255→0 with a wrap pulse every 256 cycles.
